spi_reg_peripheral: RTL and testbench

- SPI target that receives register-write frames from an external host on three `ui_in` pins.
- Drives the five 8-bit control registers consumed by `pwm_peripheral`: output enables, PWM enables and duty cycle.
- Sits in the top level between `ui_in[2:0]` and the `pwm_peripheral` register inputs. It is the producer side of the register interface that `pwm_peripheral` reads.
- Write-only: read frames are decoded, flagged and discarded.

---
 rtl/spi_reg_peripheral.sv | 136 +++++++++++++
 tb/tb_spi_reg_peripheral.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only register target: synchronizes sclk/copi/ncs into clk,
// shifts 16-bit frames {rw, addr[6:0], data[7:0]} and commits writes to five 8-bit registers.
module spi_reg_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_done,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);
  localparam logic [4:0] CNT_FULL   = 5'd16;
  localparam logic [4:0] CNT_OVR    = 5'd17;

  state_t state;
  state_t state_next;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_d;
  logic                   ncs_d;

  logic        sclk_s;
  logic        copi_s;
  logic        ncs_s;
  logic        sclk_rise;
  logic        ncs_fall;
  logic        ncs_rise;
  logic [4:0]  bit_count;
  logic [15:0] shift_reg;
  logic        frame_ok;

  // Presets match an idle bus (sclk low, ncs high) so reset itself creates no edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ncs_d     <= ncs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_fall  = ~ncs_s & ncs_d;
  assign ncs_rise  = ncs_s & ~ncs_d;

  assign frame_ok = (bit_count == CNT_FULL) && shift_reg[15] &&
                    (shift_reg[14:8] <= MAX_ADDR_L);

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    case (state)
      IDLE:   if (ncs_fall) state_next = SHIFT;
      SHIFT:  if (ncs_rise) state_next = COMMIT;
      COMMIT: begin
        state_next = IDLE;
        frame_done = frame_ok;
        frame_err  = ~frame_ok;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bit_count       <= '0;
      shift_reg       <= '0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            bit_count <= '0;
            shift_reg <= '0;
          end
        end
        SHIFT: begin
          // A chip-select rise in the same cycle ends the frame; that sclk edge is dropped.
          if (sclk_rise && !ncs_rise) begin
            shift_reg <= {shift_reg[14:0], copi_s};
            if (bit_count != CNT_OVR) bit_count <= bit_count + 5'd1;
          end
        end
        COMMIT: begin
          if (frame_ok) begin
            case (shift_reg[14:8])
              7'd0:    en_reg_out_7_0  <= shift_reg[7:0];
              7'd1:    en_reg_out_15_8 <= shift_reg[7:0];
              7'd2:    en_reg_pwm_7_0  <= shift_reg[7:0];
              7'd3:    en_reg_pwm_15_8 <= shift_reg[7:0];
              7'd4:    pwm_duty_cycle  <= shift_reg[7:0];
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed bench for spi_reg_peripheral: bit-banged SPI frames with hand-computed
// register expectations and counted frame_done / frame_err pulses.
module tb_spi_reg_peripheral;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       frame_done;
  logic       frame_err;

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;

  logic [7:0] dut_regs [5];
  logic [7:0] exp_regs [5];

  spi_reg_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .frame_done      (frame_done),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  assign dut_regs[0] = en_reg_out_7_0;
  assign dut_regs[1] = en_reg_out_15_8;
  assign dut_regs[2] = en_reg_pwm_7_0;
  assign dut_regs[3] = en_reg_pwm_15_8;
  assign dut_regs[4] = pwm_duty_cycle;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
    if (frame_done && frame_err) both_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_start();
    ncs = 1'b0;
    tick(5);
  endtask

  task automatic spi_bit(input logic b);
    copi = b;
    tick(5);
    sclk = 1'b1;
    tick(5);
    sclk = 1'b0;
  endtask

  task automatic spi_end();
    tick(5);
    ncs = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] v, input int n);
    spi_start();
    for (int i = n - 1; i >= 0; i--) spi_bit(v[i]);
    spi_end();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    sclk = 1'($urandom_range(0, 1));
    copi = 1'($urandom_range(0, 1));
    ncs  = 1'($urandom_range(0, 1));
    tick(2);
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (dut_regs[r] !== 8'h00) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h exp=00", r, dut_regs[r]);
      end
    end
    checks++;
    if ({frame_done, frame_err} !== 2'b00) begin
      failures++;
      $display("FAIL reset_pulses got=%b exp=00", {frame_done, frame_err});
    end
    sclk = 1'b0;
    copi = 1'b0;
    ncs  = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    for (int r = 0; r < 5; r++) exp_regs[r] = 8'h00;
  endtask

  task automatic test_basic_write();
    int d0;
    int e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(32'h0000_8480, 16);
    tick(3);
    checks++;
    if (pwm_duty_cycle !== 8'h00 || frame_done !== 1'b1) begin
      failures++;
      $display("FAIL basic_commit_cycle duty=%h done=%b exp duty=00 done=1",
               pwm_duty_cycle, frame_done);
    end
    tick(1);
    checks++;
    if (pwm_duty_cycle !== 8'h80 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL basic_update duty=%h done=%b exp duty=80 done=0",
               pwm_duty_cycle, frame_done);
    end
    tick(4);
    exp_regs[4] = 8'h80;
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (dut_regs[r] !== exp_regs[r]) begin
        failures++;
        $display("FAIL basic_reg%0d got=%h exp=%h", r, dut_regs[r], exp_regs[r]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      failures++;
      $display("FAIL basic_pulses done=%0d err=%0d exp done=1 err=0",
               done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_sequential();
    logic [15:0] frames [4];
    frames[0] = 16'h80F0;
    frames[1] = 16'h810F;
    frames[2] = 16'h82AA;
    frames[3] = 16'h8355;
    for (int f = 0; f < 4; f++) begin
      int d0;
      int e0;
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame({16'h0000, frames[f]}, 16);
      tick(8);
      exp_regs[f] = frames[f][7:0];
      for (int r = 0; r < 5; r++) begin
        checks++;
        if (dut_regs[r] !== exp_regs[r]) begin
          failures++;
          $display("FAIL seq%0d_reg%0d got=%h exp=%h", f, r, dut_regs[r], exp_regs[r]);
        end
      end
      checks++;
      if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
        failures++;
        $display("FAIL seq%0d_pulses done=%0d err=%0d exp done=1 err=0",
                 f, done_cnt - d0, err_cnt - e0);
      end
    end
  endtask

  task automatic test_rejects();
    logic [31:0] vals [4];
    int          lens [4];
    vals[0] = 32'h0000_04FF; lens[0] = 16;
    vals[1] = 32'h0000_85FF; lens[1] = 16;
    vals[2] = 32'h0000_4209; lens[2] = 15;
    vals[3] = 32'h0001_8411; lens[3] = 17;
    for (int k = 0; k < 4; k++) begin
      int d0;
      int e0;
      checks++;
      if (pwm_duty_cycle !== 8'h80) begin
        failures++;
        $display("FAIL reject%0d_pre duty=%h exp=80", k, pwm_duty_cycle);
      end
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame(vals[k], lens[k]);
      tick(8);
      for (int r = 0; r < 5; r++) begin
        checks++;
        if (dut_regs[r] !== exp_regs[r]) begin
          failures++;
          $display("FAIL reject%0d_reg%0d got=%h exp=%h", k, r, dut_regs[r], exp_regs[r]);
        end
      end
      checks++;
      if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
        failures++;
        $display("FAIL reject%0d_pulses done=%0d err=%0d exp done=0 err=1",
                 k, done_cnt - d0, err_cnt - e0);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] v;
    int d0;
    v = 16'h843C;
    spi_start();
    for (int i = 15; i >= 8; i--) spi_bit(v[i]);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    d0 = done_cnt;
    for (int i = 7; i >= 0; i--) spi_bit(v[i]);
    spi_end();
    tick(8);
    for (int r = 0; r < 5; r++) exp_regs[r] = 8'h00;
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (dut_regs[r] !== exp_regs[r]) begin
        failures++;
        $display("FAIL midrst_reg%0d got=%h exp=%h", r, dut_regs[r], exp_regs[r]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 0) begin
      failures++;
      $display("FAIL midrst_done got=%0d exp=0", done_cnt - d0);
    end
    d0 = done_cnt;
    send_frame({16'h0000, v}, 16);
    tick(8);
    exp_regs[4] = 8'h3C;
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (dut_regs[r] !== exp_regs[r]) begin
        failures++;
        $display("FAIL midrst_full_reg%0d got=%h exp=%h", r, dut_regs[r], exp_regs[r]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL midrst_full_done got=%0d exp=1", done_cnt - d0);
    end
  endtask

  task automatic test_idle_noise();
    int d0;
    int e0;
    d0 = done_cnt;
    e0 = err_cnt;
    ncs = 1'b1;
    for (int t = 0; t < 20; t++) begin
      copi = 1'($urandom_range(0, 1));
      tick(5);
      sclk = 1'b1;
      tick(5);
      sclk = 1'b0;
    end
    tick(5);
    checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      failures++;
      $display("FAIL noise_pulses done=%0d err=%0d exp done=0 err=0",
               done_cnt - d0, err_cnt - e0);
    end
    send_frame(32'h0000_8001, 16);
    tick(8);
    exp_regs[0] = 8'h01;
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (dut_regs[r] !== exp_regs[r]) begin
        failures++;
        $display("FAIL noise_reg%0d got=%h exp=%h", r, dut_regs[r], exp_regs[r]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      failures++;
      $display("FAIL noise_frame_pulses done=%0d err=%0d exp done=1 err=0",
               done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_exclusive_pulses();
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL pulses_exclusive got=%0d exp=0", both_cnt);
    end
  endtask

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    ncs  = 1'b1;
    tick(1);
    test_reset();
    test_basic_write();
    test_sequential();
    test_rejects();
    test_reset_mid_frame();
    test_idle_noise();
    test_exclusive_pulses();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
